// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a two-entry skid buffer.
// Operands are extended on entry and leave in order with their tag.
module imm_extend_pipe #(
  parameter int unsigned SIZE_IN  = 16,
  parameter int unsigned SIZE_OUT = 32,
  parameter int unsigned BR_SHIFT = 2,
  parameter int unsigned TAG_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE_IN-1:0]  in_imm,
  input  logic [1:0]          in_mode,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE_OUT-1:0] out_data,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int unsigned UP_SHIFT = SIZE_OUT - SIZE_IN;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [SIZE_OUT-1:0] data;
    logic [TAG_W-1:0]    tag;
  } entry_t;

  state_e state, state_nxt;
  entry_t m_q, s_q;
  entry_t new_c;

  logic [SIZE_OUT-1:0] sext_c;
  logic [SIZE_OUT-1:0] ext_c;
  logic in_xfer_c, out_xfer_c;
  logic ld_m_in, ld_m_skid, ld_s;

  // Extension: the signed cast sign-fills, including the SIZE_IN == SIZE_OUT case
  always_comb begin
    sext_c = SIZE_OUT'($signed(in_imm));
    ext_c  = sext_c;
    unique case (in_mode)
      MODE_SIGN:   ext_c = sext_c;
      MODE_ZERO:   ext_c = SIZE_OUT'(in_imm);
      MODE_UPPER:  ext_c = SIZE_OUT'(in_imm) << UP_SHIFT;
      MODE_BRANCH: ext_c = sext_c << BR_SHIFT;
      default:     ext_c = sext_c;
    endcase
  end

  always_comb begin
    new_c.data = ext_c;
    new_c.tag  = in_tag;
  end

  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid && out_ready;

  // Buffer controller: next state and register load enables
  always_comb begin
    state_nxt = state;
    ld_m_in   = 1'b0;
    ld_m_skid = 1'b0;
    ld_s      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_xfer_c) begin
          ld_m_in   = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer_c && out_xfer_c) begin
          ld_m_in = 1'b1;
        end else if (in_xfer_c) begin
          ld_s      = 1'b1;
          state_nxt = ST_FULL;
        end else if (out_xfer_c) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer_c) begin
          ld_m_skid = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over every transfer and drops any concurrent input
    if (flush) begin
      state_nxt = ST_EMPTY;
      ld_m_in   = 1'b0;
      ld_m_skid = 1'b0;
      ld_s      = 1'b0;
    end
  end

  // State and handshake flags are registered so in_ready never sees out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != ST_FULL);
      out_valid <= (state_nxt != ST_EMPTY);
    end
  end

  // Main register holds steady unless it is reloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
    end else if (ld_m_in) begin
      m_q <= new_c;
    end else if (ld_m_skid) begin
      m_q <= s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else if (ld_s) begin
      s_q <= new_c;
    end
  end

  assign out_data = m_q.data;
  assign out_tag  = m_q.tag;

endmodule
